// File: rtl/bilbo_bist_controller_if.sv
// Bus between the BILBO BIST controller and the datapath/system side.
// The master drives the mode lines, the scan input and the result; the slave drives Start and So.
interface bilbo_bist_controller_if #(
   parameter int N = 4
);
   logic         Start;
   logic         So;
   logic         B1;
   logic         B2;
   logic         Si;
   logic         Busy;
   logic         Done;
   logic         Pass;
   logic [N:0]   Signature;

   modport master (
      input  Start, So,
      output B1, B2, Si, Busy, Done, Pass, Signature
   );

   modport slave (
      output Start, So,
      input  B1, B2, Si, Busy, Done, Pass, Signature
   );
endinterface

// File: rtl/bilbo_bist_controller.sv
// BIST sequencer for a RegA/RegB PRPG + RegC MISR BILBO datapath: clear, seed the scan chain,
// run the test clocks, scan the RegC signature back in and compare it against GOLDEN.
module bilbo_bist_controller #(
   parameter int             N      = 4,
   parameter int             NPAT   = 15,
   parameter logic [3*N:0]   SEED   = 13'h1A5B,
   parameter logic [N:0]     GOLDEN = '0
) (
   input  logic                      Clk_i,
   input  logic                      Rst_i,
   bilbo_bist_controller_if.master   bus
);
   localparam int CHAIN = 3 * N + 1;
   localparam int MAXC  = (CHAIN > NPAT) ? CHAIN : NPAT;
   localparam int CW    = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] SEED_LAST = CW'(CHAIN - 1);
   localparam logic [CW-1:0] TEST_LAST = CW'(NPAT - 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(N);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SEED, S_TEST, S_SCAN, S_CMP, S_DONE
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              b1_q, b2_q, si_q;
   logic              busy_q, done_q, pass_q;
   logic [N:0]        sig_q;
   logic [CHAIN-1:0]  seed_sr_q;

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         b1_q      <= 1'b1;
         b2_q      <= 1'b0;
         si_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         sig_q     <= '0;
         seed_sr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.Start) begin
                  state_q <= S_CLEAR;
                  b1_q    <= 1'b0;
                  b2_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  sig_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            S_CLEAR: begin
               // Si carries SEED[0] in seed cycle 0; the rest is fed from a shift copy.
               state_q   <= S_SEED;
               b1_q      <= 1'b0;
               b2_q      <= 1'b0;
               si_q      <= SEED[0];
               seed_sr_q <= SEED >> 1;
               cnt_q     <= '0;
            end
            S_SEED: begin
               if (cnt_q == SEED_LAST) begin
                  state_q <= S_TEST;
                  b1_q    <= 1'b1;
                  b2_q    <= 1'b1;
                  si_q    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  si_q      <= seed_sr_q[0];
                  seed_sr_q <= seed_sr_q >> 1;
                  cnt_q     <= cnt_q + 1'b1;
               end
            end
            S_TEST: begin
               if (cnt_q == TEST_LAST) begin
                  state_q <= S_SCAN;
                  b1_q    <= 1'b0;
                  b2_q    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SCAN: begin
               // Shifting in from the top leaves the first sampled bit in Signature[0].
               sig_q <= {bus.So, sig_q[N:1]};
               if (cnt_q == SCAN_LAST) begin
                  state_q <= S_CMP;
                  b1_q    <= 1'b1;
                  b2_q    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_CMP: begin
               state_q <= S_DONE;
               pass_q  <= (sig_q == GOLDEN);
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.B1        = b1_q;
   assign bus.B2        = b2_q;
   assign bus.Si        = si_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.Pass      = pass_q;
   assign bus.Signature = sig_q;
endmodule

// File: tb/tb_bilbo_bist_controller.sv
// Directed bench for bilbo_bist_controller: per-cycle mode/Si trace checks inline, and a
// scoreboard queue of expected Signature/Pass/latency popped by a monitor on each Done rise.
module tb_bilbo_bist_controller;
   localparam int N = 4;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   bilbo_bist_controller_if #(.N(N)) bus ();

   bilbo_bist_controller #(
      .N      (N),
      .NPAT   (15),
      .SEED   (13'h1A5B),
      .GOLDEN (5'h0D)
   ) dut (
      .Clk_i (Clk),
      .Rst_i (Rst),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0] sig;
      logic       pass;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   seed_bits[13] = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_mode(input int j);
      if (j == 0)  return 2'b01;
      if (j <= 13) return 2'b00;
      if (j <= 28) return 2'b11;
      if (j <= 33) return 2'b00;
      return 2'b10;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_mode"}, {30'd0, bus.B1, bus.B2}, 32'd2);
      chk({tag, "_si"},   {31'd0, bus.Si},   32'd0);
      chk({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.Done}, 32'd0);
      chk({tag, "_pass"}, {31'd0, bus.Pass}, 32'd0);
      chk({tag, "_sig"},  {27'd0, bus.Signature}, 32'd0);
   endtask

   // One BIST run from the Start-sampling edge; optionally hold Start, pulse Start in TEST, or abort.
   task automatic run(input logic [4:0] so_pat, input logic [4:0] exp_sig, input logic exp_pass,
                      input bit hold, input bit pulse_test, input int abort_at);
      bus.Start = 1'b1;
      if (abort_at < 0) exp_q.push_back('{exp_sig, exp_pass, 35});
      @(posedge Clk); #1;
      start_cyc = cyc;
      if (!hold) bus.Start = 1'b0;
      for (int j = 0; j <= 34; j++) begin
         bus.So = (j >= 29 && j <= 33) ? so_pat[j-29] : 1'b0;
         if (pulse_test) bus.Start = (j == 18 || j == 22);
         if (j == abort_at) begin
            Rst = 1'b1;
            @(posedge Clk); #1;
            Rst = 1'b0;
            bus.Start = 1'b0;
            bus.So = 1'b0;
            @(negedge Clk);
            chk_reset("abort");
            $display("[TB] run aborted by reset at cycle %0d", j);
            return;
         end
         @(negedge Clk);
         chk($sformatf("mode_c%0d", j), {30'd0, bus.B1, bus.B2}, {30'd0, exp_mode(j)});
         chk($sformatf("si_c%0d", j), {31'd0, bus.Si},
             (j >= 1 && j <= 13) ? 32'(seed_bits[j-1]) : 32'd0);
         chk($sformatf("busy_c%0d", j), {31'd0, bus.Busy}, 32'd1);
         chk($sformatf("done_c%0d", j), {31'd0, bus.Done}, 32'd0);
         @(posedge Clk); #1;
      end
      bus.So = 1'b0;
      @(negedge Clk);
      chk("end_busy", {31'd0, bus.Busy}, 32'd0);
      chk("end_done", {31'd0, bus.Done}, 32'd1);
      chk("end_mode", {30'd0, bus.B1, bus.B2}, 32'd2);
      $display("[TB] run so=%b sig=%h pass=%0d", so_pat, bus.Signature, bus.Pass);
   endtask

   // Monitor: pops an expectation on each rising edge of Done.
   initial begin
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (bus.Done === 1'b1 && !prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: Done rose with no run expected (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               chk("signature", {27'd0, bus.Signature}, {27'd0, e.sig});
               chk("pass", {31'd0, bus.Pass}, {31'd0, e.pass});
               chk("latency", cyc - start_cyc, e.lat);
               $display("[TB] done: sig=%h pass=%0d latency=%0d", bus.Signature, bus.Pass,
                        cyc - start_cyc);
            end
         end
         prev = (bus.Done === 1'b1);
      end
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Start = 1'b1;
      bus.So    = 1'b0;
      Rst       = 1'b1;
      // Reset with Start held: reset wins, outputs at reset values.
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk_reset("reset");
      $display("[TB] reset checked");
      bus.Start = 1'b0;
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk_reset("idle");

      // Matching signature 0D -> pass.
      run(5'b01101, 5'h0D, 1'b1, 1'b0, 1'b0, -1);
      // Bit 4 flipped -> 1D, fail; Done still asserted.
      run(5'b11101, 5'h1D, 1'b0, 1'b0, 1'b0, -1);
      // Start held high: immediate re-trigger from DONE.
      run(5'b01101, 5'h0D, 1'b1, 1'b1, 1'b0, -1);
      run(5'b00000, 5'h00, 1'b0, 1'b0, 1'b0, -1);
      // Start pulses in TEST ignored; reset in SCAN cycle 2 aborts.
      run(5'b01101, 5'h0D, 1'b1, 1'b0, 1'b1, 31);
      repeat (40) @(posedge Clk);
      @(negedge Clk);
      chk_reset("post_abort");
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
